im_arbiter: RTL and testbench
=============================

IM_ARBITER -- requirements
Module: im_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_REQ, default 4, number of requesting cores (legal 2..8); BURST, default 4, maximum consecutive grants to one owner while others wait (legal 1..15).
REQ-002 Ports SHALL be, name direction width meaning:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  fetch request per core.
- req_addr  input  13*NUM_REQ  fetch address; core i uses bits [13i+12:13i].
- gnt  output  NUM_REQ  registered one-hot grant; address accepted this cycle.
- rvld  output  NUM_REQ  registered one-hot; rdata belongs to that core.
- rdata  output  20  registered fetched instruction.
- im_addr  output  13  registered address to the instruction memory.
- im_instr  input  20  instruction memory data, latched by memory on clk falling edge.
- busy  output  1  high while the FSM is in OWN.
REQ-003 The block SHALL use the single clock clk; reset SHALL be asynchronous and active-high on rst.

Function
REQ-004 On each rising edge with any req bit high, the arbiter SHALL select exactly one winner w, set gnt to one-hot w and set im_addr to req_addr slice w.
REQ-005 On a rising edge with req all zero, gnt SHALL go to 0 and im_addr SHALL hold its value.
REQ-006 On the rising edge after a grant to w, rvld SHALL be one-hot w and rdata SHALL equal im_instr; otherwise rvld SHALL be 0 and rdata SHALL hold.
REQ-007 Latency SHALL be one cycle from req sampled to gnt, and one further cycle from gnt to rvld; throughput SHALL be one fetch per cycle.
REQ-008 A core seeing gnt[i] high SHALL be considered served; it may change req_addr or drop req for the next edge without loss.
REQ-009 The FSM SHALL have states IDLE (no owner) and OWN (owner o, 4-bit burst counter bc).
REQ-010 IDLE with a request SHALL grant the first requesting index at or after rr_ptr (wrapping), enter OWN with o=w, bc=1.
REQ-011 In OWN, if req[o] is high and (bc<BURST or no other req bit is high), the arbiter SHALL grant o again and set bc=min(bc+1,15).
REQ-012 In OWN, if req[o] is low or bc==BURST with another requester pending, the arbiter SHALL grant the first requesting index after o (wrapping), set o to it, bc=1, and rr_ptr=o+1 mod NUM_REQ.
REQ-013 In OWN with req all zero, the FSM SHALL return to IDLE with rr_ptr=o+1 mod NUM_REQ.
REQ-014 Requests from cores that drop req before grant SHALL be ignored without side effect.
REQ-015 No requester that keeps req high SHALL wait more than (NUM_REQ-1)*BURST cycles for gnt.

Reset
REQ-016 While rst is high: gnt=0, rvld=0, rdata=0, im_addr=0, busy=0, state=IDLE, rr_ptr=0, bc=0.
REQ-017 A reset asserted between gnt and rvld SHALL discard that fetch; no rvld SHALL be produced for it after reset release.
REQ-018 The first rising edge after rst deasserts SHALL arbitrate normally per REQ-010.

Configuration
REQ-019 With macro IM_ARB_STATS_EN defined, the block SHALL add input stat_clr (1) and output stat_cnt (16*NUM_REQ), one saturating 16-bit grant counter per core, incremented on each gnt, cleared by rst or synchronous stat_clr (clear wins over increment).
REQ-020 Without IM_ARB_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-021 Single request: req=4'b0010, addr1=13'h0A5, memory[0A5]=20'h12345 -> gnt=0010 next edge, rvld=0010 and rdata=20'h12345 one edge later.
REQ-022 Burst limit: req=4'b1111 held, BURST=4 -> grant sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0; rvld trails gnt by one cycle.
REQ-023 Sole owner: req=4'b0100 held 20 cycles -> gnt=0100 every cycle; bc saturates at 15; no idle gap.
REQ-024 Owner drop: core 0 owns with bc=2, req becomes 4'b1000 -> next gnt=1000, bc=1, rr_ptr=0.
REQ-025 Reset mid-fetch: rst pulsed in the cycle gnt=0001 -> rvld stays 0, all outputs 0, and the first post-reset grant follows REQ-010 from rr_ptr=0.
REQ-026 With IM_ARB_STATS_EN: 70000 grants to core 2 -> stat_cnt slice 2 = 16'hFFFF; stat_clr coincident with gnt -> 0.

Source files
------------

// File: rtl/im_arbiter.sv
// Burst-limited round-robin arbiter sharing one instruction memory port among NUM_REQ cores.
// Optional per-core grant statistics are enabled with the IM_ARB_STATS_EN macro.
module im_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned BURST   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [13*NUM_REQ-1:0] req_addr,
    output logic [NUM_REQ-1:0]    gnt,
    output logic [NUM_REQ-1:0]    rvld,
    output logic [19:0]           rdata,
    output logic [12:0]           im_addr,
    input  logic [19:0]           im_instr,
    output logic                  busy
`ifdef IM_ARB_STATS_EN
   ,input  logic                  stat_clr,
    output logic [16*NUM_REQ-1:0] stat_cnt
`endif
);

    localparam int unsigned IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned AW  = 13;
    localparam int unsigned BCW = 4;

    typedef enum logic {IDLE, OWN} state_e;

    state_e          state_q;
    logic [IW-1:0]   owner_q;
    logic [IW-1:0]   rr_ptr_q;
    logic [BCW-1:0]  bc_q;

    logic [NUM_REQ-1:0] own_mask;
    logic               any_req;
    logic               others_pend;
    logic               keep_owner;
    logic [IW-1:0]      win_idle;
    logic [IW-1:0]      win_next;

    function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
        return (i == IW'(NUM_REQ - 1)) ? '0 : i + IW'(1);
    endfunction

    // First requesting index at or after start, wrapping around.
    function automatic logic [IW-1:0] pick_from(input logic [NUM_REQ-1:0] r,
                                                input logic [IW-1:0]      start);
        logic [IW-1:0] res;
        logic          found;
        int unsigned   idx;
        res   = start;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(start) + k) % NUM_REQ;
            if (!found && r[IW'(idx)]) begin
                res   = IW'(idx);
                found = 1'b1;
            end
        end
        return res;
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
        return NUM_REQ'(1) << i;
    endfunction

    always_comb begin
        own_mask    = onehot(owner_q);
        any_req     = |req;
        others_pend = |(req & ~own_mask);
        keep_owner  = req[owner_q] && ((bc_q < BCW'(BURST)) || !others_pend);
        win_idle    = pick_from(req, rr_ptr_q);
        win_next    = pick_from(req, wrap_inc(owner_q));
    end

    // Arbitration FSM with registered grant, address, and read-return outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            bc_q     <= '0;
            gnt      <= '0;
            rvld     <= '0;
            rdata    <= '0;
            im_addr  <= '0;
            busy     <= 1'b0;
        end else begin
            rvld <= gnt;
            if (|gnt) begin
                rdata <= im_instr;
            end
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        state_q <= OWN;
                        owner_q <= win_idle;
                        bc_q    <= BCW'(1);
                        gnt     <= onehot(win_idle);
                        im_addr <= req_addr[AW*win_idle +: AW];
                        busy    <= 1'b1;
                    end else begin
                        gnt  <= '0;
                        busy <= 1'b0;
                    end
                end
                OWN: begin
                    if (!any_req) begin
                        state_q  <= IDLE;
                        rr_ptr_q <= wrap_inc(owner_q);
                        gnt      <= '0;
                        busy     <= 1'b0;
                    end else if (keep_owner) begin
                        bc_q    <= (bc_q == '1) ? bc_q : bc_q + BCW'(1);
                        gnt     <= own_mask;
                        im_addr <= req_addr[AW*owner_q +: AW];
                        busy    <= 1'b1;
                    end else begin
                        owner_q  <= win_next;
                        rr_ptr_q <= wrap_inc(win_next);
                        bc_q     <= BCW'(1);
                        gnt      <= onehot(win_next);
                        im_addr  <= req_addr[AW*win_next +: AW];
                        busy     <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt     <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef IM_ARB_STATS_EN
    logic [15:0] stat_q [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
        // Saturating grant counter; a synchronous clear beats a coincident grant.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                stat_q[i] <= '0;
            end else if (stat_clr) begin
                stat_q[i] <= '0;
            end else if (gnt[i] && (stat_q[i] != 16'hFFFF)) begin
                stat_q[i] <= stat_q[i] + 16'd1;
            end
        end
        assign stat_cnt[16*i +: 16] = stat_q[i];
    end
`endif

endmodule

// File: tb/tb_im_arbiter.sv
// Directed table-driven bench for im_arbiter (NUM_REQ=4, BURST=4) with a behavioural memory.
module tb_im_arbiter;

    localparam int unsigned N = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  req;
    logic [13*N-1:0] req_addr;
    logic [N-1:0]  gnt;
    logic [N-1:0]  rvld;
    logic [19:0]   rdata;
    logic [12:0]   im_addr;
    logic [19:0]   im_instr;
    logic          busy;
`ifdef IM_ARB_STATS_EN
    logic          stat_clr;
    logic [16*N-1:0] stat_cnt;
`endif

    im_arbiter #(.NUM_REQ(N), .BURST(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .rvld     (rvld),
        .rdata    (rdata),
        .im_addr  (im_addr),
        .im_instr (im_instr),
        .busy     (busy)
`ifdef IM_ARB_STATS_EN
       ,.stat_clr (stat_clr),
        .stat_cnt (stat_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [19:0] mem [0:8191];

    always @(negedge clk) im_instr = mem[im_addr];

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] exp_gnt;
    } vec_t;

    vec_t tbl [14];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned idx_of(input logic [3:0] oh);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < N; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic check_zero_outputs(input string tag);
        check({tag, " gnt"},     32'(gnt),     32'h0);
        check({tag, " rvld"},    32'(rvld),    32'h0);
        check({tag, " rdata"},   32'(rdata),   32'h0);
        check({tag, " im_addr"}, 32'(im_addr), 32'h0);
        check({tag, " busy"},    32'(busy),    32'h0);
    endtask

    logic [3:0]  prev_gnt;
    logic [12:0] prev_addr;
    logic [12:0] exp_addr;
    logic [19:0] exp_rdata;
    logic [3:0]  exp_g;

    initial begin
        for (int a = 0; a < 8192; a++) mem[a] = 20'(a * 37 + 20'h0ABCD);
        mem[13'h0A5] = 20'h12345;
        req      = '0;
        req_addr = '0;
        im_instr = '0;
`ifdef IM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif

        // Hand-computed sequence starting from reset (rr_ptr=0, IDLE).
        tbl[0]  = '{req: 4'b0010, exp_gnt: 4'b0010};
        tbl[1]  = '{req: 4'b0000, exp_gnt: 4'b0000};
        tbl[2]  = '{req: 4'b0000, exp_gnt: 4'b0000};
        tbl[3]  = '{req: 4'b0011, exp_gnt: 4'b0001};
        tbl[4]  = '{req: 4'b0011, exp_gnt: 4'b0001};
        tbl[5]  = '{req: 4'b1000, exp_gnt: 4'b1000};
        tbl[6]  = '{req: 4'b0000, exp_gnt: 4'b0000};
        tbl[7]  = '{req: 4'b0110, exp_gnt: 4'b0010};
        tbl[8]  = '{req: 4'b0100, exp_gnt: 4'b0100};
        tbl[9]  = '{req: 4'b0101, exp_gnt: 4'b0100};
        tbl[10] = '{req: 4'b0101, exp_gnt: 4'b0100};
        tbl[11] = '{req: 4'b0101, exp_gnt: 4'b0100};
        tbl[12] = '{req: 4'b0101, exp_gnt: 4'b0001};
        tbl[13] = '{req: 4'b0000, exp_gnt: 4'b0000};

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        prev_gnt  = '0;
        prev_addr = '0;
        exp_addr  = '0;
        exp_rdata = '0;
        for (int v = 0; v < 14; v++) begin
            req = tbl[v].req;
            for (int i = 0; i < N; i++) req_addr[13*i +: 13] = 13'(13'h200 * i + v);
            if (v == 0) req_addr[13 +: 13] = 13'h0A5;
            tick();
            check($sformatf("vec%0d gnt", v),  32'(gnt),  32'(tbl[v].exp_gnt));
            check($sformatf("vec%0d rvld", v), 32'(rvld), 32'(prev_gnt));
            check($sformatf("vec%0d busy", v), 32'(busy), 32'(|tbl[v].exp_gnt));
            if (tbl[v].exp_gnt != 0) exp_addr = req_addr[13*idx_of(tbl[v].exp_gnt) +: 13];
            check($sformatf("vec%0d im_addr", v), 32'(im_addr), 32'(exp_addr));
            if (prev_gnt != 0) exp_rdata = mem[prev_addr];
            check($sformatf("vec%0d rdata", v), 32'(rdata), 32'(exp_rdata));
            prev_gnt  = tbl[v].exp_gnt;
            prev_addr = exp_addr;
        end

        // Burst limit with all four cores requesting continuously.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'hF;
        for (int i = 0; i < N; i++) req_addr[13*i +: 13] = 13'(13'h300 + i);
        prev_gnt = '0;
        for (int k = 0; k < 17; k++) begin
            tick();
            exp_g = 4'(1) << ((k / 4) % 4);
            check($sformatf("burst%0d gnt", k),  32'(gnt),  32'(exp_g));
            check($sformatf("burst%0d rvld", k), 32'(rvld), 32'(prev_gnt));
            prev_gnt = exp_g;
        end

        // Sole owner long enough to require counter saturation.
        req = 4'b0100;
        for (int k = 0; k < 33; k++) begin
            tick();
            check($sformatf("sole%0d gnt", k), 32'(gnt), 32'h4);
            check($sformatf("sole%0d busy", k), 32'(busy), 32'h1);
        end
        req = 4'b0101;
        tick();
        check("sat handoff gnt", 32'(gnt), 32'h1);
        req = 4'b0000;
        tick();
        check("drain gnt", 32'(gnt), 32'h0);
        check("drain busy", 32'(busy), 32'h0);

        // Reset in the cycle the grant is visible discards the fetch.
        req = 4'b0001;
        tick();
        check("midrst pre gnt", 32'(gnt), 32'h1);
        rst = 1'b1;
        req = 4'b0110;
        #1;
        check_zero_outputs("midrst async");
        tick();
        check("midrst held rvld", 32'(rvld), 32'h0);
        rst = 1'b0;
        tick();
        check("postrst gnt", 32'(gnt), 32'h2);
        check("postrst rvld", 32'(rvld), 32'h0);
        tick();
        check("postrst rvld2", 32'(rvld), 32'h2);

`ifdef IM_ARB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 4'b0100;
        for (int k = 0; k < 70001; k++) @(posedge clk);
        #1;
        check("stat sat", 32'(stat_cnt[32 +: 16]), 32'hFFFF);
        check("stat other", 32'(stat_cnt[0 +: 16]), 32'h0);
        stat_clr = 1'b1;
        tick();
        stat_clr = 1'b0;
        check("stat clr gnt", 32'(gnt), 32'h4);
        check("stat clr", 32'(stat_cnt[32 +: 16]), 32'h0);
        req = 4'b0000;
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
